// File: rtl/inner_loop_resolve_if.sv
// ---------------------------------------------------------------------------
// inner_loop_resolve_if
// Carries the redundant r0/r1 pair from the inner Montgomery loop to the
// carry-propagate resolver, and carries the resolved sum back to the outer
// loop.
//   master : inner/outer loop side (drives en, r0, r1)
//   slave  : resolver side (drives busy, sum, low_limb, en_out)
// Signals:
//   en       start strobe; r0/r1 are sampled when it is accepted
//   r0, r1   redundant operands, W bits each
//   busy     an add is in progress
//   sum      resolved r0+r1, W+1 bits
//   low_limb sum[SIZE_BI-1:0]
//   en_out   one-cycle pulse: sum is valid
// W and SIZE_BI must match the resolver's Size+Size_bi+2 and Size_bi.
// ---------------------------------------------------------------------------
interface inner_loop_resolve_if #(
  parameter int W       = 3138,
  parameter int SIZE_BI = 64
);
  logic               en;
  logic [W-1:0]       r0;
  logic [W-1:0]       r1;
  logic               busy;
  logic [W:0]         sum;
  logic [SIZE_BI-1:0] low_limb;
  logic               en_out;

  modport master (
    output en, r0, r1,
    input  busy, sum, low_limb, en_out
  );

  modport slave (
    input  en, r0, r1,
    output busy, sum, low_limb, en_out
  );
endinterface

// File: rtl/inner_loop_resolve.sv
// ---------------------------------------------------------------------------
// inner_loop_resolve
// Resolves the redundant pair r0/r1 produced by the inner Montgomery loop
// into a single binary value using one Chunk-bit adder reused over NR rounds
// (least significant chunk first, carry kept in a register between rounds).
// The full sum and its low limb are presented to the outer loop.
// Ports:
//   clk    clock, all state updates on the rising edge
//   rst_n  synchronous active-low reset
//   bus    inner_loop_resolve_if.slave (en, r0, r1 in; busy, sum,
//          low_limb, en_out out)
// Timing: en accepted at edge 0, rounds at edges 1..NR, en_out high for the
// cycle after edge NR. en while busy is ignored.
// ---------------------------------------------------------------------------
module inner_loop_resolve #(
  parameter int Size    = 3072,
  parameter int Size_bi = 64,
  parameter int Chunk   = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inner_loop_resolve_if.slave  bus
);

  localparam int W  = Size + Size_bi + 2;
  localparam int NR = (W + Chunk - 1) / Chunk;
  localparam int RW = (NR > 1) ? $clog2(NR) : 1;
  localparam logic [RW-1:0] LAST_ROUND = RW'(NR - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [RW-1:0] r_round;
  logic          r_carry;
  logic [W-1:0]  r_op0;
  logic [W-1:0]  r_op1;
  logic [W:0]    r_sum;
  logic [W:0]    w_sum_next;
  logic          w_accept;
  logic          w_adding;
  logic [Chunk-1:0] w_a [NR];
  logic [Chunk-1:0] w_b [NR];
  logic [Chunk:0]   w_add;

  // A new operation may start whenever no add is running (IDLE or DONE).
  assign w_accept = bus.en && (r_state != ADD);
  assign w_adding = (r_state == ADD);

  // Operand chunk slices. The top chunk is narrower than Chunk and is
  // zero-extended so bits above W-1 read as 0.
  for (genvar gi = 0; gi < NR; gi++) begin : g_slice
    localparam int LO = gi * Chunk;
    if ((gi == NR - 1) && (W - LO < Chunk)) begin : g_top
      assign w_a[gi] = {{(Chunk - (W - LO)){1'b0}}, r_op0[W-1:LO]};
      assign w_b[gi] = {{(Chunk - (W - LO)){1'b0}}, r_op1[W-1:LO]};
    end else begin : g_full
      assign w_a[gi] = r_op0[LO +: Chunk];
      assign w_b[gi] = r_op1[LO +: Chunk];
    end
  end

  // Single shared adder; the round counter selects which chunk it works on.
  assign w_add = {1'b0, w_a[r_round]} + {1'b0, w_b[r_round]}
               + {{Chunk{1'b0}}, r_carry};

  // Next value of the sum register: only the chunk of the current round
  // changes. The top chunk takes one extra adder bit so the final carry
  // lands in sum[W].
  for (genvar gi = 0; gi < NR; gi++) begin : g_sum
    localparam int LO = gi * Chunk;
    localparam int HI = (gi == NR - 1) ? W : (LO + Chunk - 1);
    assign w_sum_next[HI:LO] = (w_adding && (r_round == RW'(gi)))
                             ? w_add[HI-LO:0] : r_sum[HI:LO];
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_next = ADD;
      end
      ADD: begin
        if (r_round == LAST_ROUND) w_state_next = DONE;
      end
      DONE: begin
        w_state_next = w_accept ? ADD : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op0   <= '0;
      r_op1   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_round <= '0;
    end else begin
      r_sum <= w_sum_next;
      if (w_accept) begin
        r_op0   <= bus.r0;
        r_op1   <= bus.r1;
        r_carry <= 1'b0;
        r_round <= '0;
      end else if (w_adding) begin
        r_carry <= w_add[Chunk];
        r_round <= r_round + 1'b1;
      end
    end
  end

  assign bus.busy     = w_adding;
  assign bus.en_out   = (r_state == DONE);
  assign bus.sum      = r_sum;
  assign bus.low_limb = r_sum[Size_bi-1:0];

endmodule

// File: tb/tb_inner_loop_resolve.sv
// ---------------------------------------------------------------------------
// tb_inner_loop_resolve
// Directed vectors with hand-computed sums for inner_loop_resolve, plus
// sequences for en-while-busy, back-to-back starts and mid-add reset.
// ---------------------------------------------------------------------------
module tb_inner_loop_resolve;

  localparam int SIZE    = 3072;
  localparam int SIZE_BI = 64;
  localparam int CHUNK   = 1024;
  localparam int W       = SIZE + SIZE_BI + 2;
  localparam int WS      = W + 1;
  localparam int NV      = 7;

  logic clk;
  logic rst_n;

  inner_loop_resolve_if #(.W(W), .SIZE_BI(SIZE_BI)) bus ();

  inner_loop_resolve #(
    .Size(SIZE), .Size_bi(SIZE_BI), .Chunk(CHUNK)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  r0;
    logic [W-1:0]  r1;
    logic [WS-1:0] exp_sum;
    logic [63:0]   exp_low;
  } vec_t;

  vec_t vecs [NV];

  int n_cmp;
  int n_bad;
  int cyc;
  int busy_cnt;
  int pulse_cnt;
  int pulse_at [4];

  task automatic check_wide(input string name, input logic [WS-1:0] act,
                            input logic [WS-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got top=%h low=%h, expected top=%h low=%h",
               name, act[WS-1:WS-67], act[63:0], exp[WS-1:WS-67], exp[63:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One cycle: wait for the falling edge, then sample busy/en_out.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus.busy === 1'b1) busy_cnt++;
    if (bus.en_out === 1'b1) begin
      if (pulse_cnt < 4) pulse_at[pulse_cnt] = cyc;
      pulse_cnt++;
    end
  endtask

  task automatic clear_counts();
    busy_cnt  = 0;
    pulse_cnt = 0;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    tick();
    clear_counts();
    bus.en = 1'b1;
    bus.r0 = a;
    bus.r1 = b;
    tick();
    bus.en = 1'b0;
    bus.r0 = '0;
    bus.r1 = '0;
    repeat (9) tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    clear_counts();
    bus.en = 1'b0;
    bus.r0 = '0;
    bus.r1 = '0;

    // Vector table (hand-derived sums)
    vecs[0].r0 = W'(1);                     vecs[0].r1 = W'(1);
    vecs[0].exp_sum = WS'(2);               vecs[0].exp_low = 64'h2;
    vecs[1].r0 = (W'(1) << 3072) - W'(1);   vecs[1].r1 = W'(1);
    vecs[1].exp_sum = WS'(1) << 3072;       vecs[1].exp_low = 64'h0;
    vecs[2].r0 = '1;                        vecs[2].r1 = '1;
    vecs[2].exp_sum = ~(WS'(1));            vecs[2].exp_low = 64'hFFFF_FFFF_FFFF_FFFE;
    vecs[3].r0 = W'(1) << 1023;             vecs[3].r1 = W'(1) << 1023;
    vecs[3].exp_sum = WS'(1) << 1024;       vecs[3].exp_low = 64'h0;
    vecs[4].r0 = W'(1) << 3137;             vecs[4].r1 = W'(1) << 3137;
    vecs[4].exp_sum = WS'(1) << 3138;       vecs[4].exp_low = 64'h0;
    vecs[5].r0 = W'(64'hDEAD_BEEF);         vecs[5].r1 = W'(64'h1111_1111);
    vecs[5].exp_sum = WS'(64'hEFBE_D000);   vecs[5].exp_low = 64'hEFBE_D000;
    vecs[6].r0 = '0;                        vecs[6].r1 = '0;
    vecs[6].exp_sum = '0;                   vecs[6].exp_low = 64'h0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check_int("reset_busy", {31'b0, bus.busy}, 0);
    check_int("reset_en_out", {31'b0, bus.en_out}, 0);
    check_wide("reset_sum", bus.sum, '0);
    check_wide("reset_low", WS'(bus.low_limb), '0);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].r0, vecs[i].r1);
      $display("vec %0d: sum low=%h busy_cycles=%0d pulses=%0d",
               i, bus.sum[63:0], busy_cnt, pulse_cnt);
      check_wide($sformatf("vec%0d_sum", i), bus.sum, vecs[i].exp_sum);
      check_wide($sformatf("vec%0d_low", i), WS'(bus.low_limb), WS'(vecs[i].exp_low));
      check_int($sformatf("vec%0d_busy_cycles", i), busy_cnt, 4);
      check_int($sformatf("vec%0d_pulses", i), pulse_cnt, 1);
    end

    // en while busy is ignored
    tick();
    clear_counts();
    bus.en = 1'b1; bus.r0 = W'(5); bus.r1 = W'(7);
    tick();
    check_int("ign_busy_at_second_en", {31'b0, bus.busy}, 1);
    bus.en = 1'b1; bus.r0 = '1; bus.r1 = '1;
    tick();
    bus.en = 1'b0; bus.r0 = '0; bus.r1 = '0;
    repeat (8) tick();
    $display("ignore-while-busy: sum low=%h pulses=%0d", bus.sum[63:0], pulse_cnt);
    check_wide("ign_sum", bus.sum, WS'(12));
    check_int("ign_pulses", pulse_cnt, 1);
    check_int("ign_busy_cycles", busy_cnt, 4);

    // Back-to-back: second en in the en_out cycle
    tick();
    clear_counts();
    bus.en = 1'b1; bus.r0 = W'(3); bus.r1 = W'(4);
    tick();
    bus.en = 1'b0;
    repeat (4) tick();
    check_int("b2b_first_en_out", {31'b0, bus.en_out}, 1);
    check_wide("b2b_first_sum", bus.sum, WS'(7));
    bus.en = 1'b1; bus.r0 = W'(10); bus.r1 = W'(20);
    tick();
    bus.en = 1'b0; bus.r0 = '0; bus.r1 = '0;
    repeat (8) tick();
    $display("back-to-back: sum low=%h pulses=%0d", bus.sum[63:0], pulse_cnt);
    check_wide("b2b_second_sum", bus.sum, WS'(30));
    check_int("b2b_pulses", pulse_cnt, 2);
    if (pulse_cnt >= 2) begin
      check_int("b2b_spacing", pulse_at[1] - pulse_at[0], 5);
    end

    // Reset during round 2 aborts the add
    tick();
    clear_counts();
    bus.en = 1'b1; bus.r0 = '1; bus.r1 = '1;
    tick();
    bus.en = 1'b0; bus.r0 = '0; bus.r1 = '0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_wide("rst_mid_sum", bus.sum, '0);
    check_int("rst_mid_busy", {31'b0, bus.busy}, 0);
    clear_counts();
    repeat (6) tick();
    $display("reset mid-add: sum low=%h pulses=%0d", bus.sum[63:0], pulse_cnt);
    check_int("rst_mid_no_pulse", pulse_cnt, 0);
    run_op(W'(1), W'(1));
    $display("after reset: sum low=%h pulses=%0d", bus.sum[63:0], pulse_cnt);
    check_wide("rst_after_sum", bus.sum, WS'(2));
    check_int("rst_after_pulses", pulse_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inner_loop_resolve.md
Name: inner_loop_resolve

Overview:
- Consumer at the far end of the inner-loop output interface.
- Takes the redundant pair r0/r1 (low-half and limb-shifted high-half partial-product sums, each Size+Size_bi+2 bits) on the inner loop's completion strobe.
- Resolves the pair into one binary value with a multi-cycle carry-propagate adder, Chunk bits per cycle.
- Presents the full sum and its low limb to the outer Montgomery loop, which uses the low limb for the next quotient digit.

Parameters:
- Size, 3072, operand width in bits.
- Size_bi, 64, limb width in bits.
- Chunk, 1024, bits added per cycle (16 limbs).
- W, Size+Size_bi+2 (3138), derived, width of r0/r1.
- NR, ceil(W/Chunk) (4), derived, number of add rounds.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- en  in  1  start strobe (the inner loop's completion pulse); samples r0/r1.
- r0  in  W  redundant operand 0.
- r1  in  W  redundant operand 1.
- busy  out  1  high while an add is in progress.
- sum  out  W+1  resolved value r0+r1; held stable until the next accepted en.
- low_limb  out  Size_bi  sum[Size_bi-1:0], same timing as sum.
- en_out  out  1  one-cycle pulse: sum is valid.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, busy=0, en_out=0, sum=0, low_limb=0, round counter=0, carry=0, operand registers=0. Reset mid-operation aborts the add; no en_out follows.
- States: IDLE, ADD, DONE.
- IDLE/DONE, en=1:
  - Latch r0, r1 into internal registers.
  - Clear carry, round=0, go to ADD, busy=1.
  - sum keeps its old value until overwritten chunk by chunk.
- ADD, round k (0..NR-1):
  - sum chunk k = reg0[Chunk*k +: Chunk] + reg1[Chunk*k +: Chunk] + carry.
  - Store carry-out; round=k+1.
  - Bits above W-1 read as 0.
  - Last round (k=NR-1) covers bits 3072..3138: 66-bit operands zero-extended, sum written to bits 3072..3138, so the final carry lands in sum[W].
- After round NR-1: go to DONE, busy=0, en_out=1 for exactly one cycle, low_limb=sum[63:0].
- DONE → IDLE next cycle unless en is accepted.
- Latency: en sampled at edge 0; rounds at edges 1..NR; en_out high in the cycle after edge NR (4 add cycles, pulse after edge 4 for defaults).
- Back-to-back: en asserted in the DONE cycle is accepted (busy=0). en_out still pulses for the finished result; the new operation begins.
- en while busy=1 is ignored: no re-latch, no restart, result unaffected.
- r0/r1 are sampled only on the accepted en edge; later changes have no effect.
- Arithmetic is unsigned, exact, no overflow (W+1 output bits).

Test Plan:
- r0=1, r1=1, en pulse → busy high 4 cycles, en_out single pulse, sum=2, low_limb=2.
- r0=2^3072-1, r1=1 → sum=2^3072 (carry ripples across all chunk boundaries), low_limb=0.
- r0=r1=2^3138-1 → sum=2^3139-2 (sum[3138]=1), low_limb=0xFFFF_FFFF_FFFF_FFFE.
- Start with r0=5, r1=7; during busy pulse en with r0=r1=all ones → en ignored, sum=12, exactly one en_out.
- Two operations, second en in the en_out cycle (r0=3,r1=4 then r0=10,r1=20) → sums 7 then 30, two en_out pulses 5 cycles apart.
- rst_n=0 during round 2 of an add → sum=0, busy=0, no en_out; a following en with r0=r1=1 yields sum=2.
